// File: rtl/seq_detect_param.sv
// Run-time programmable serial pattern detector with overlap control and a
// saturating match counter. Pattern MSB (pattern[len-1]) is the first bit received.
module seq_detect_param #(
  parameter int MAX_LEN   = 8,
  parameter int CNT_WIDTH = 8,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load,
  input  logic [MAX_LEN-1:0]   pattern,
  input  logic [LEN_W-1:0]     pattern_len,
  input  logic                 overlap,
  input  logic                 i_valid,
  input  logic                 i,
  input  logic                 clear_count,
  output logic                 o,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 cfg_err,
  output logic                 armed
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SEARCH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   cfg_pat_q, cfg_pat_d;
  logic [LEN_W-1:0]     cfg_len_q, cfg_len_d;
  logic                 cfg_ovl_q, cfg_ovl_d;
  logic [MAX_LEN-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]     fill_q, fill_d;
  logic                 o_q, o_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [MAX_LEN-1:0]   hist_shift_s;
  logic [MAX_LEN-1:0]   len_mask_s;
  logic [LEN_W-1:0]     fill_inc_s;
  logic                 len_ok_s;
  logic                 match_s;
  logic                 cnt_inc_s;

  // Candidate history/fill after accepting the current bit, and the match decision on it
  always_comb begin
    hist_shift_s = {hist_q[MAX_LEN-2:0], i};
    fill_inc_s   = (fill_q < cfg_len_q) ? (fill_q + LEN_W'(1)) : fill_q;
    len_mask_s   = ~({MAX_LEN{1'b1}} << cfg_len_q);
    match_s      = (fill_inc_s == cfg_len_q) &&
                   (((hist_shift_s ^ cfg_pat_q) & len_mask_s) == {MAX_LEN{1'b0}});
    len_ok_s     = (pattern_len >= LEN_W'(1)) && (pattern_len <= LEN_W'(MAX_LEN));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cfg_pat_d = cfg_pat_q;
    cfg_len_d = cfg_len_q;
    cfg_ovl_d = cfg_ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cfg_err_d = cfg_err_q;
    o_d       = 1'b0;
    cnt_inc_s = 1'b0;

    if (load) begin
      if (len_ok_s) begin
        cfg_pat_d = pattern;
        cfg_len_d = pattern_len;
        cfg_ovl_d = overlap;
        hist_d    = {MAX_LEN{1'b0}};
        fill_d    = {LEN_W{1'b0}};
        cfg_err_d = 1'b0;
        state_d   = ST_FILL;
      end else begin
        cfg_err_d = 1'b1;
        state_d   = ST_IDLE;
      end
    end else if ((state_q != ST_IDLE) && i_valid) begin
      if (match_s) begin
        o_d       = 1'b1;
        cnt_inc_s = 1'b1;
        if (cfg_ovl_q) begin
          hist_d  = hist_shift_s;
          fill_d  = fill_inc_s;
          state_d = ST_SEARCH;
        end else begin
          // Non-overlapping: the matched bits may not start another match
          hist_d  = {MAX_LEN{1'b0}};
          fill_d  = {LEN_W{1'b0}};
          state_d = ST_FILL;
        end
      end else begin
        hist_d  = hist_shift_s;
        fill_d  = fill_inc_s;
        state_d = (fill_inc_s == cfg_len_q) ? ST_SEARCH : ST_FILL;
      end
    end else begin
      state_d = state_q;
    end

    if (clear_count) begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end else if (cnt_inc_s && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and configuration registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      cfg_pat_q <= {MAX_LEN{1'b0}};
      cfg_len_q <= {LEN_W{1'b0}};
      cfg_ovl_q <= 1'b0;
      hist_q    <= {MAX_LEN{1'b0}};
      fill_q    <= {LEN_W{1'b0}};
      o_q       <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cfg_pat_q <= cfg_pat_d;
      cfg_len_q <= cfg_len_d;
      cfg_ovl_q <= cfg_ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      o_q       <= o_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o           = o_q;
  assign match_count = cnt_q;
  assign cfg_err     = cfg_err_q;
  assign armed       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic, both checked
// every cycle against a queue-based reference model; two DUTs differ only in CNT_WIDTH.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pattern_len;
  logic               overlap;
  logic               i_valid;
  logic               i;
  logic               clear_count;
  logic               o, o2;
  logic [7:0]         match_count;
  logic [1:0]         match_count2;
  logic               cfg_err, cfg_err2;
  logic               armed, armed2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_WIDTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .load(load), .pattern(pattern), .pattern_len(pattern_len),
    .overlap(overlap), .i_valid(i_valid), .i(i), .clear_count(clear_count),
    .o(o), .match_count(match_count), .cfg_err(cfg_err), .armed(armed)
  );

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .load(load), .pattern(pattern), .pattern_len(pattern_len),
    .overlap(overlap), .i_valid(i_valid), .i(i), .clear_count(clear_count),
    .o(o2), .match_count(match_count2), .cfg_err(cfg_err2), .armed(armed2)
  );

  // Reference model: received bits kept oldest-first in a queue
  bit       m_q[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl, m_armed, m_err, m_o;
  int       m_cnt8, m_cnt2;

  function automatic bit model_hit();
    if (m_q.size() != m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_q[k] != m_pat[m_len-1-k]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!n_rst) begin
      m_q.delete();
      m_pat = '0; m_len = 0; m_ovl = 0; m_armed = 0; m_err = 0; m_o = 0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      m_o = 0;
      if (load) begin
        if (pattern_len >= 1 && pattern_len <= MAX_LEN) begin
          m_pat = pattern; m_len = int'(pattern_len); m_ovl = overlap;
          m_q.delete(); m_err = 0; m_armed = 1;
        end else begin
          m_err = 1; m_armed = 0;
        end
      end else if (m_armed && i_valid) begin
        m_q.push_back(i);
        if (m_q.size() > m_len) void'(m_q.pop_front());
        if (model_hit()) begin
          m_o = 1;
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
          if (!m_ovl) m_q.delete();
        end
      end
      if (clear_count) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("o", {31'd0, o}, {31'd0, m_o});
      chk("count8", {24'd0, match_count}, 32'(m_cnt8));
      chk("err", {31'd0, cfg_err}, {31'd0, m_err});
      chk("armed", {31'd0, armed}, {31'd0, m_armed});
      chk("o_w2", {31'd0, o2}, {31'd0, m_o});
      chk("count2", {30'd0, match_count2}, 32'(m_cnt2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    load = 1'b0; i_valid = 1'b0; i = 1'b0; clear_count = 1'b0;
  endtask

  task automatic drive(input logic v, input logic b);
    i_valid = v; i = b;
    tick();
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] len, input logic ovl);
    load = 1'b1; pattern = p; pattern_len = len; overlap = ovl; clear_count = 1'b1;
    tick();
  endtask

  task automatic run_bits(input logic [15:0] bits, input logic [15:0] expo, input int n,
                          input string nm);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, bits[n-1-k]);
      chk(nm, {31'd0, o}, {31'd0, expo[n-1-k]});
    end
  endtask

  initial begin
    n_rst = 1'b0; load = 1'b0; pattern = '0; pattern_len = '0; overlap = 1'b0;
    i_valid = 1'b0; i = 1'b0; clear_count = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_armed", {31'd0, armed}, 32'd0);
    chk("rst_cnt", {24'd0, match_count}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    n_rst = 1'b1;

    do_load(8'b1101, 4'd4, 1'b1);
    chk("load_armed", {31'd0, armed}, 32'd1);
    run_bits(16'b1101101, 16'b0001001, 7, "ovl_1101");
    chk("ovl_1101_cnt", {24'd0, match_count}, 32'd2);

    do_load(8'b1101, 4'd4, 1'b0);
    run_bits(16'b1101101, 16'b0001000, 7, "novl_1101");
    chk("novl_1101_cnt", {24'd0, match_count}, 32'd1);

    do_load(8'b111, 4'd3, 1'b1);
    run_bits(16'b11111, 16'b00111, 5, "ovl_111");
    chk("ovl_111_cnt", {24'd0, match_count}, 32'd3);
    do_load(8'b111, 4'd3, 1'b0);
    run_bits(16'b11111, 16'b00100, 5, "novl_111");
    chk("novl_111_cnt", {24'd0, match_count}, 32'd1);

    do_load(8'b1101, 4'd4, 1'b1);
    run_bits(16'b11, 16'b00, 2, "gap_a");
    drive(1'b0, 1'b1); chk("gap_idle1", {31'd0, o}, 32'd0);
    drive(1'b0, 1'b0); chk("gap_idle2", {31'd0, o}, 32'd0);
    run_bits(16'b01, 16'b01, 2, "gap_b");
    drive(1'b0, 1'b1); chk("gap_after", {31'd0, o}, 32'd0);
    chk("gap_cnt", {24'd0, match_count}, 32'd1);

    load = 1'b1; pattern = 8'b1101; pattern_len = 4'd0; tick();
    chk("len0_err", {31'd0, cfg_err}, 32'd1);
    chk("len0_armed", {31'd0, armed}, 32'd0);
    run_bits(16'b1101, 16'b0000, 4, "len0_ignored");
    chk("len0_cnt", {24'd0, match_count}, 32'd1);
    load = 1'b1; pattern_len = 4'd9; tick();
    chk("len9_err", {31'd0, cfg_err}, 32'd1);
    chk("len9_armed", {31'd0, armed}, 32'd0);

    do_load(8'b1, 4'd1, 1'b0);
    chk("len1_err_clr", {31'd0, cfg_err}, 32'd0);
    run_bits(16'b111111, 16'b111111, 6, "len1");
    chk("sat_cnt2", {30'd0, match_count2}, 32'd3);
    chk("sat_cnt8", {24'd0, match_count}, 32'd6);
    clear_count = 1'b1; drive(1'b1, 1'b1);
    chk("clr_o", {31'd0, o}, 32'd1);
    chk("clr_cnt", {24'd0, match_count}, 32'd0);
    chk("clr_cnt2", {30'd0, match_count2}, 32'd0);

    do_load(8'b1101, 4'd4, 1'b1);
    run_bits(16'b110, 16'b000, 3, "pre_rst");
    n_rst = 1'b0; tick(); n_rst = 1'b1;
    chk("mid_rst_armed", {31'd0, armed}, 32'd0);
    chk("mid_rst_o", {31'd0, o}, 32'd0);
    chk("mid_rst_cnt", {24'd0, match_count}, 32'd0);
    run_bits(16'b1, 16'b0, 1, "post_rst");

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        load = 1'b1;
        pattern = 8'($urandom);
        case ($urandom_range(0, 9))
          0:       pattern_len = 4'd0;
          1:       pattern_len = 4'd9;
          2, 3:    pattern_len = 4'($urandom_range(5, 8));
          default: pattern_len = 4'($urandom_range(1, 4));
        endcase
        overlap = 1'($urandom);
      end
      clear_count = ($urandom_range(0, 59) == 0);
      n_rst = ($urandom_range(0, 499) != 0);
      drive(($urandom_range(0, 9) < 7), 1'($urandom));
      n_rst = 1'b1;
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
